// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises rstn deassertion, then releases NUM_STAGES
// active-low resets in index order with STAGE_DLY cycles between releases.
module rst_seq_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DLY   = 16,
    parameter int SW_HOLD     = 8,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_rstn,
    output logic                  seq_busy,
    output logic                  seq_done
);

    localparam logic [1:0] ST_RST    = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_SW_HLD = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stg_q, stg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  step;
    logic                  enter_hold;
    logic [CNT_W-1:0]      base;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // Every edge that enters COUNT is also its first counting edge, so the
    // release arithmetic is shared through 'step' with a starting count 'base'.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stg_d      = stg_q;
        busy_d     = busy_q;
        done_d     = done_q;
        step       = 1'b0;
        enter_hold = 1'b0;
        base       = '0;

        case (state_q)
            ST_RST: begin
                if (rst_sync) begin
                    step   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            ST_COUNT: begin
                if (sw_rst_req) begin
                    enter_hold = 1'b1;
                end else begin
                    step = 1'b1;
                    base = cnt_q;
                end
            end
            ST_SW_HLD: begin
                if (cnt_q == HOLD_LAST) begin
                    step = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (sw_rst_req) begin
                    enter_hold = 1'b1;
                end
            end
            default: state_d = ST_RST;
        endcase

        if (enter_hold) begin
            state_d = ST_SW_HLD;
            stg_d   = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
        end

        if (step) begin
            state_d = ST_COUNT;
            cnt_d   = base;
            if (en) begin
                if (base == DLY_LAST) begin
                    stg_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = base + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            idx_q   <= '0;
            stg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign stage_rstn = stg_q;
    assign seq_busy   = busy_q;
    assign seq_done   = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: edge-indexed vector table per scenario,
// plus a small-parameter instance and a continuous stage-ordering check.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       sw;
    logic [3:0] stg;
    logic       busy;
    logic       done;
    logic [0:0] w_stg;
    logic       w_busy;
    logic       w_done;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;
    int en_lo_s, en_lo_e, sw_e1, sw_e2;

    rst_seq_ctrl dut (
        .clk(clk), .rstn(rstn), .en(en), .sw_rst_req(sw),
        .stage_rstn(stg), .seq_busy(busy), .seq_done(done)
    );

    rst_seq_ctrl #(.NUM_STAGES(1), .SYNC_STAGES(3), .STAGE_DLY(1)) dut_small (
        .clk(clk), .rstn(rstn), .en(en), .sw_rst_req(1'b0),
        .stage_rstn(w_stg), .seq_busy(w_busy), .seq_done(w_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         scen;
        int         edge_no;
        logic [3:0] stg;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int scen, input int e, input logic [3:0] s,
                       input logic b, input logic d);
        vec_t v;
        v.scen = scen; v.edge_no = e; v.stg = s; v.busy = b; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bits must always form a contiguous run from bit 0.
    always @(negedge clk) begin
        logic [3:0] t;
        if (rstn) begin
            t = stg & (stg + 4'd1);
            check($sformatf("order e%0d", edge_n), {28'd0, t}, 32'd0);
        end
    end

    task automatic step_edge();
        en = !((edge_n + 1) >= en_lo_s && (edge_n + 1) <= en_lo_e);
        sw = (edge_n == sw_e1) || (edge_n == sw_e2);
        @(posedge clk);
        edge_n++;
        #1;
        if (edge_n > 400) begin
            $display("FAIL timeout: edge %0d exceeds 400", edge_n);
            $fatal(1);
        end
    endtask

    // Short rstn pulse between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        check({tag, " rst stg"},  {28'd0, stg}, 32'd0);
        check({tag, " rst busy"}, {31'd0, busy}, 32'd0);
        check({tag, " rst done"}, {31'd0, done}, 32'd0);
        #2;
        rstn   = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        int cur;
        rstn = 1'b1; en = 1'b1; sw = 1'b0;
        en_lo_s = 0; en_lo_e = -1; sw_e1 = -1; sw_e2 = -1;
        #1 rstn = 1'b0;
        #2;
        check("por stg",  {28'd0, stg}, 32'd0);
        check("por busy", {31'd0, busy}, 32'd0);
        check("por done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;

        // scen 0: power-on release, then software request at edge 100 from DONE
        add(0,   2, 4'b0000, 0, 0);  add(0,   3, 4'b0000, 1, 0);
        add(0,  17, 4'b0000, 1, 0);  add(0,  18, 4'b0001, 1, 0);
        add(0,  33, 4'b0001, 1, 0);  add(0,  34, 4'b0011, 1, 0);
        add(0,  50, 4'b0111, 1, 0);  add(0,  65, 4'b0111, 1, 0);
        add(0,  66, 4'b1111, 0, 1);  add(0, 100, 4'b1111, 0, 1);
        add(0, 101, 4'b0000, 1, 0);  add(0, 123, 4'b0000, 1, 0);
        add(0, 124, 4'b0001, 1, 0);  add(0, 171, 4'b0111, 1, 0);
        add(0, 172, 4'b1111, 0, 1);
        // scen 1: en low for edges 25..34
        add(1,  18, 4'b0001, 1, 0);  add(1,  34, 4'b0001, 1, 0);
        add(1,  43, 4'b0001, 1, 0);  add(1,  44, 4'b0011, 1, 0);
        add(1,  60, 4'b0111, 1, 0);  add(1,  75, 4'b0111, 1, 0);
        add(1,  76, 4'b1111, 0, 1);
        // scen 2: request mid-sequence at edge 40, ignored one at edge 45
        add(2,  40, 4'b0011, 1, 0);  add(2,  41, 4'b0000, 1, 0);
        add(2,  46, 4'b0000, 1, 0);  add(2,  63, 4'b0000, 1, 0);
        add(2,  64, 4'b0001, 1, 0);  add(2,  80, 4'b0011, 1, 0);
        add(2, 111, 4'b0111, 1, 0);  add(2, 112, 4'b1111, 0, 1);
        // scen 3: 3 ns rstn glitch out of DONE restarts from the synchroniser
        add(3,   2, 4'b0000, 0, 0);  add(3,  17, 4'b0000, 1, 0);
        add(3,  18, 4'b0001, 1, 0);  add(3,  66, 4'b1111, 0, 1);

        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].scen != cur) begin
                cur = vecs[i].scen;
                en_lo_s = 0; en_lo_e = -1; sw_e1 = -1; sw_e2 = -1;
                if (cur == 0) sw_e1 = 100;
                if (cur == 1) begin en_lo_s = 25; en_lo_e = 34; end
                if (cur == 2) begin sw_e1 = 40; sw_e2 = 45; end
                if (cur != 0) do_reset($sformatf("s%0d", cur));
                else begin
                    rstn = 1'b1;
                    edge_n = 0;
                end
            end
            while (edge_n < vecs[i].edge_no) step_edge();
            check($sformatf("s%0d e%0d stg", cur, edge_n), {28'd0, stg}, {28'd0, vecs[i].stg});
            check($sformatf("s%0d e%0d busy", cur, edge_n), {31'd0, busy}, {31'd0, vecs[i].busy});
            check($sformatf("s%0d e%0d done", cur, edge_n), {31'd0, done}, {31'd0, vecs[i].done});
        end

        // small instance: 3-flop synchroniser, single stage, delay 1
        en_lo_s = 0; en_lo_e = -1; sw_e1 = -1; sw_e2 = -1;
        do_reset("small");
        while (edge_n < 3) step_edge();
        check("small e3 stg",  {31'd0, w_stg},  32'd0);
        check("small e3 done", {31'd0, w_done}, 32'd0);
        step_edge();
        check("small e4 stg",  {31'd0, w_stg},  32'd1);
        check("small e4 done", {31'd0, w_done}, 32'd1);
        check("small e4 busy", {31'd0, w_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer for the asynchronous-reset flop population.
- Takes the board-level asynchronous reset and synchronises its deassertion.
- Releases NUM_STAGES downstream active-low resets one at a time, with a fixed delay between stages.
- Lets software re-run the whole sequence via a request pulse. Sits at top level, one instance per clock domain.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (>=1).
- SYNC_STAGES, 2, reset synchroniser depth (>=2).
- STAGE_DLY, 16, clk cycles between successive stage releases (>=1, <=2^CNT_W-1).
- SW_HOLD, 8, cycles all outputs are held asserted after a software request (>=1).
- CNT_W, 8, delay counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low; clock clk
- en  in  1  sequence enable; delay counter advances only while high
- sw_rst_req  in  1  single-cycle software reset request
- stage_rstn  out  NUM_STAGES  sequenced active-low resets; bit 0 released first
- seq_busy  out  1  high while a release sequence or software hold is in progress
- seq_done  out  1  high when all stages are released

Behaviour:
- Reset: rstn low clears the synchroniser, counter, stage index and FSM immediately (async).
  - stage_rstn=0 (all asserted), seq_busy=0, seq_done=0, state=RST.
- Synchroniser: SYNC_STAGES-flop chain clocked by clk, async-cleared by rstn, D of first flop tied to 1. rst_sync=last flop.
- Edge numbering: edge 1 = first rising clk edge at which rstn is high.
- FSM states: RST, COUNT, SW_HLD, DONE.
- RST -> COUNT when rst_sync=1.
  - seq_busy rises on edge SYNC_STAGES+1 (with defaults).
  - Counter starts from 0, stage index=0.
- COUNT:
  - Counter increments each cycle en=1 and holds when en=0.
  - When the counter reaches STAGE_DLY-1 with en=1: set stage_rstn[idx]=1, clear the counter, idx++.
  - On release of the last stage: go to DONE, seq_done=1, seq_busy=0 on that same edge.
- Release timing with en held high: stage_rstn[k] rises on edge SYNC_STAGES + (k+1)*STAGE_DLY.
  - Defaults: edges 18, 34, 50, 66.
- Stage ordering: released stages never re-assert except via rstn or sw_rst_req. stage_rstn is monotonic: bits rise in index order, so stage_rstn[k]=1 implies stage_rstn[j]=1 for all j<k.
- en low mid-sequence: pauses only. Already-released stages stay released; the counter value is retained.
- sw_rst_req=1 in COUNT or DONE: on the next edge go to SW_HLD.
  - stage_rstn=0 (all), seq_done=0, seq_busy=1, counter cleared.
- SW_HLD: counts SW_HOLD cycles, independent of en, then -> COUNT with idx=0. The synchroniser is not re-run.
  - Stage 0 releases SW_HOLD+STAGE_DLY edges after the request edge.
- sw_rst_req in RST or SW_HLD: ignored; the hold is not extended.
- sw_rst_req on the same edge a stage would release: the request wins; no output rises.
- rstn assertion at any time: all outputs return to reset values immediately, asynchronously; the sequence restarts from the synchroniser on deassertion.
- rstn glitch shorter than one clk period: still fully asserts all outputs asynchronously.
- Outputs are registered; no combinational path from inputs to outputs except rstn.

Test Plan:
- Power-on, defaults, en=1 -> stage_rstn goes 0000 -> 0001@edge18 -> 0011@34 -> 0111@50 -> 1111@66. seq_done=1 and seq_busy=0 at edge 66.
- en dropped for 10 cycles starting edge 25 -> stage1 releases at edge 44 instead of 34, stage0 stays 1 throughout, final release at edge 76.
- sw_rst_req pulse at edge 100 in DONE -> stage_rstn=0000 and seq_done=0 at edge 101; stage0 rises at edge 124 (100+8+16); all released at edge 172.
- sw_rst_req at edge 40 (mid-sequence, stage_rstn=0011) -> 0000 at edge 41, then stage0 at edge 64. A second request at edge 45 (in SW_HLD) is ignored.
- rstn pulsed low for 3 ns at an arbitrary point after DONE -> stage_rstn=0000 and seq_done=0 immediately, without waiting for a clock edge. Counting from the first edge with rstn high, stage0 releases at edge 18.
- Parameter sweep NUM_STAGES=1, STAGE_DLY=1, SYNC_STAGES=3 -> stage_rstn[0] and seq_done rise at edge 4. Check that at no cycle does any bit rise before a lower-index bit.
